uart_rx: RTL
============

# uart_rx

Serial-to-parallel UART receiver: the downstream counterpart of `uart_tx` on the same 8-N-1 line at the same `CLKS_PER_BIT` rate. It synchronises the asynchronous serial input, qualifies the start bit at mid-bit, samples 8 data bits LSB first, and checks the stop bit. Each good byte is delivered as a one-cycle `o_Rx_DV` strobe to the consuming logic (APB register block / RX FIFO).

## Interface
- `CLKS_PER_BIT`, default 87: system clocks per serial bit. Legal range 4..2047; the counter is 11 bits.
- `i_Clock`  in  1  system clock; all logic on rising edge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Rx_Serial`  in  1  asynchronous serial line; idles high.
- `o_Rx_DV`  out  1  one-cycle strobe: `o_Rx_Byte` holds a valid new byte.
- `o_Rx_Byte`  out  8  last received byte; held until the next `o_Rx_DV`.
- `o_Rx_Active`  out  1  high from start-bit qualification until return to IDLE.
- `o_Rx_Frame_Err`  out  1  one-cycle strobe: stop bit sampled low.
- `o_Rx_Parity_Err`  out  1  one-cycle strobe: parity mismatch. Constant 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- **Input synchroniser.** Two-flop synchroniser on `i_Rx_Serial`; both flops reset to 1. All decisions use the synchronised bit `r_Rx`.
- **Bit counter.** Bit index counts 0..7.
- **s_IDLE.** Clock count is 0 and bit index is 0. If `r_Rx`==0, go to s_RX_START_BIT.
- **s_RX_START_BIT.** Count up to `(CLKS_PER_BIT-1)/2` (integer division), then re-check `r_Rx`.
  - If `r_Rx`==0: clear the count, set `o_Rx_Active`, go to s_RX_DATA_BITS.
  - If `r_Rx`==1: the start was a glitch; return to s_IDLE with no outputs asserted.
- **s_RX_DATA_BITS.** Count `CLKS_PER_BIT-1`, then sample `r_Rx` into `r_Rx_Byte[bit_index]` and clear the count.
  - After bit 7: go to s_RX_PARITY_BIT if the macro is defined, otherwise to s_RX_STOP_BIT.
- **s_RX_STOP_BIT.** Count `CLKS_PER_BIT-1`, then sample `r_Rx`.
  - If 1: load `o_Rx_Byte`, pulse `o_Rx_DV`, go to s_CLEANUP.
  - If 0: pulse `o_Rx_Frame_Err`, do not pulse `o_Rx_DV`, leave `o_Rx_Byte` unchanged, go to s_WAIT_IDLE.
- **s_CLEANUP.** Lasts one cycle. Clear `o_Rx_Active`, go to s_IDLE.
- **s_WAIT_IDLE.** Handles break or line stuck low. Stay until `r_Rx`==1, then clear `o_Rx_Active` and go to s_IDLE. No new start bit is detected while in this state.
- **Unused state encodings.** Go to s_IDLE.
- **Reset.** Reset at any point, including mid-frame, does the following:
  - returns to s_IDLE;
  - clears the counter, bit index and `r_Rx_Byte`;
  - forces all outputs to their reset values; no partial byte is ever delivered.

## Timing
- **Reset values.** `o_Rx_DV`=0, `o_Rx_Byte`=8'h00, `o_Rx_Active`=0, `o_Rx_Frame_Err`=0, `o_Rx_Parity_Err`=0.
- **Synchroniser delay.** 2 cycles from an `i_Rx_Serial` edge to `r_Rx`.
- **Sample points.** Start bit is checked at half a bit; data, parity and stop bits are sampled at their mid-bit points, spaced `CLKS_PER_BIT` apart.
- **DV latency.** `o_Rx_DV` rises in the cycle after the stop-bit sample. `o_Rx_Byte` is valid in that same cycle.
- **Strobe width.** `o_Rx_DV`, `o_Rx_Frame_Err` and `o_Rx_Parity_Err` are each high for exactly 1 cycle.
- **No backpressure.** The consumer must capture the byte on the strobe cycle.
- **Back-to-back frames.** A new start bit is accepted directly after s_CLEANUP. Minimum frame spacing is 10 bits (11 with parity).

## Configuration
- **`UART_RX_PARITY_EN` defined.**
  - Frame is start + 8 data + even parity + stop.
  - s_RX_PARITY_BIT samples at mid-bit and compares the sample with the XOR of the 8 data bits.
  - On mismatch, `o_Rx_Parity_Err` pulses in the same cycle as `o_Rx_DV`. The byte is still delivered.
- **`UART_RX_PARITY_EN` not defined.**
  - Frame is 8-N-1, compatible with `uart_tx`.
  - The s_RX_PARITY_BIT state is not compiled in.
  - `o_Rx_Parity_Err` is tied to 0.

## Structure
- **Package `uart_pkg`.** Holds:
  - the state encodings shared with `uart_tx` (3-bit: s_IDLE, s_*_START_BIT, s_*_DATA_BITS, s_*_STOP_BIT, s_CLEANUP, s_RX_PARITY_BIT, s_WAIT_IDLE);
  - the default `CLKS_PER_BIT`;
  - the counter width constant (11).
- **Sub-module `uart_rx_sync`.** The 2-flop synchroniser, with reset value 1, so it can be reused on other asynchronous inputs.

## Test plan
Benches use `CLKS_PER_BIT`=8 unless stated.
1. Receive 0xA5 as 8-N-1 → exactly one `o_Rx_DV` pulse with `o_Rx_Byte`=8'hA5, 1 cycle after the stop-bit mid-point; no error strobes.
2. `uart_tx`→`uart_rx` loopback at the default 87: send 0x00, 0xFF, 0x3C back-to-back → three DV pulses carrying the same bytes in order.
3. Line low for 2 cycles only (glitch shorter than half a bit) → no DV and no error; `o_Rx_Active` stays 0; FSM back in s_IDLE.
4. Send 0x55 with stop bit 0, line held low for 30 cycles → `o_Rx_Frame_Err` pulses once, no DV, `o_Rx_Byte` unchanged; the next frame starts only after the line returns high and is then received correctly.
5. Assert `i_Reset` for 1 cycle during data bit 4 → all outputs at their reset values the next cycle; a following 0x81 frame is received correctly.
6. With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 → DV with byte 8'h07 and `o_Rx_Parity_Err`=1 in the same cycle; send 0x07 with parity bit 1 → DV with no error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit rate and counter width.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 87;
  localparam int unsigned CNT_W                = 11;

  typedef enum logic [2:0] {
    s_IDLE          = 3'd0,
    s_RX_START_BIT  = 3'd1,
    s_RX_DATA_BITS  = 3'd2,
    s_RX_STOP_BIT   = 3'd3,
    s_CLEANUP       = 3'd4,
    s_RX_PARITY_BIT = 3'd5,
    s_WAIT_IDLE     = 3'd6
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, received byte and status strobes out.
interface uart_rx_if;

  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Parity_Err;

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Active,
    input  o_Rx_Frame_Err,
    input  o_Rx_Parity_Err
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Active,
    output o_Rx_Frame_Err,
    output o_Rx_Parity_Err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops reset to RESET_VAL.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic r_Meta;
  logic r_Sync;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Meta <= RESET_VAL;
      r_Sync <= RESET_VAL;
    end else begin
      r_Meta <= i_Async;
      r_Sync <= r_Meta;
    end
  end

  assign o_Sync = r_Sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8-N-1 by default; define UART_RX_PARITY_EN for 8-E-1 with a parity-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  uart_rx_if.slave rx
);

  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             w_Rx;
  rx_state_e        r_State;
  logic [CNT_W-1:0] r_Clk_Count;
  logic [2:0]       r_Bit_Index;
  logic [7:0]       r_Rx_Byte;
  logic [7:0]       r_Out_Byte;
  logic             r_Rx_DV;
  logic             r_Active;
  logic             r_Frame_Err;
`ifdef UART_RX_PARITY_EN
  logic             r_Parity_Bad;
  logic             r_Parity_Err;
`endif

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (rx.i_Rx_Serial),
    .o_Sync  (w_Rx)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State      <= s_IDLE;
      r_Clk_Count  <= '0;
      r_Bit_Index  <= '0;
      r_Rx_Byte    <= '0;
      r_Out_Byte   <= '0;
      r_Rx_DV      <= 1'b0;
      r_Active     <= 1'b0;
      r_Frame_Err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_Parity_Bad <= 1'b0;
      r_Parity_Err <= 1'b0;
`endif
    end else begin
      r_Rx_DV     <= 1'b0;
      r_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_Parity_Err <= 1'b0;
`endif
      case (r_State)
        s_IDLE: begin
          r_Clk_Count <= '0;
          r_Bit_Index <= '0;
          if (!w_Rx) r_State <= s_RX_START_BIT;
        end
        // Re-check at half a bit so short glitches are rejected.
        s_RX_START_BIT: begin
          if (r_Clk_Count == LP_HALF) begin
            r_Clk_Count <= '0;
            if (!w_Rx) begin
              r_Active <= 1'b1;
              r_State  <= s_RX_DATA_BITS;
            end else begin
              r_State <= s_IDLE;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 1'b1;
          end
        end
        s_RX_DATA_BITS: begin
          if (r_Clk_Count == LP_LAST) begin
            r_Clk_Count            <= '0;
            r_Rx_Byte[r_Bit_Index] <= w_Rx;
            if (r_Bit_Index == 3'd7) begin
              r_Bit_Index <= '0;
`ifdef UART_RX_PARITY_EN
              r_State     <= s_RX_PARITY_BIT;
`else
              r_State     <= s_RX_STOP_BIT;
`endif
            end else begin
              r_Bit_Index <= r_Bit_Index + 3'd1;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        s_RX_PARITY_BIT: begin
          if (r_Clk_Count == LP_LAST) begin
            r_Clk_Count  <= '0;
            r_Parity_Bad <= w_Rx ^ (^r_Rx_Byte);
            r_State      <= s_RX_STOP_BIT;
          end else begin
            r_Clk_Count <= r_Clk_Count + 1'b1;
          end
        end
`endif
        s_RX_STOP_BIT: begin
          if (r_Clk_Count == LP_LAST) begin
            r_Clk_Count <= '0;
            if (w_Rx) begin
              r_Out_Byte   <= r_Rx_Byte;
              r_Rx_DV      <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_Parity_Err <= r_Parity_Bad;
`endif
              r_State      <= s_CLEANUP;
            end else begin
              r_Frame_Err <= 1'b1;
              r_State     <= s_WAIT_IDLE;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 1'b1;
          end
        end
        s_CLEANUP: begin
          r_Active <= 1'b0;
          r_State  <= s_IDLE;
        end
        // Break or stuck-low line: no start detection until the line recovers.
        s_WAIT_IDLE: begin
          if (w_Rx) begin
            r_Active <= 1'b0;
            r_State  <= s_IDLE;
          end
        end
        default: r_State <= s_IDLE;
      endcase
    end
  end

  assign rx.o_Rx_DV        = r_Rx_DV;
  assign rx.o_Rx_Byte      = r_Out_Byte;
  assign rx.o_Rx_Active    = r_Active;
  assign rx.o_Rx_Frame_Err = r_Frame_Err;
`ifdef UART_RX_PARITY_EN
  assign rx.o_Rx_Parity_Err = r_Parity_Err;
`else
  assign rx.o_Rx_Parity_Err = 1'b0;
`endif

endmodule
